// File: rtl/down_timer.sv
// down_timer: programmable prescaled down-counter with one-shot/periodic reload and sticky irq
module down_timer #(
  parameter int WIDTH = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH-1:0]       load_value,
  input  logic [PRESC_WIDTH-1:0] load_presc,
  input  logic                   periodic,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   irq_clear,
  output logic [WIDTH-1:0]       value,
  output logic                   running,
  output logic                   tc_pulse,
  output logic                   irq
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic                   state;
  logic [WIDTH-1:0]       reload;
  logic [PRESC_WIDTH-1:0] div;
  logic [PRESC_WIDTH-1:0] psc;
  logic                   per;
  logic                   tick;
  logic                   term;
  assign running    = state;
  assign load_ready = state == IDLE;
  assign tick       = state == RUN && !stop && psc == div;
  assign term       = tick && value == WIDTH'(1);
  // load/start/stop control, prescaler and count; stop suppresses a coinciding tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      value    <= '0;
      reload   <= '0;
      div      <= '0;
      psc      <= '0;
      per      <= 1'b0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= term;
      if (state == IDLE) begin
        if (load_valid) begin
          reload <= load_value;
          value  <= load_value;
          div    <= load_presc;
          psc    <= '0;
          per    <= periodic;
        end else if (start && value != '0) begin
          state <= RUN;
          psc   <= '0;
        end
      end else if (stop) begin
        state <= IDLE;
        psc   <= '0;
      end else if (tick) begin
        psc <= '0;
        if (term) begin
          value <= per ? reload : '0;
          state <= per ? RUN : IDLE;
        end else begin
          value <= value - WIDTH'(1);
        end
      end else begin
        psc <= psc + PRESC_WIDTH'(1);
      end
    end
  end
  // sticky terminal-count flag; a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else irq <= term ? 1'b1 : irq_clear ? 1'b0 : irq;
  end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer
module tb_down_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_value = '0;
  logic [3:0] load_presc = '0;
  logic       periodic = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       irq_clear = 1'b0;
  logic [7:0] value;
  logic       running;
  logic       tc_pulse;
  logic       irq;
  int         n_run = 0;
  int         n_fail = 0;

  down_timer #(.WIDTH(8), .PRESC_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_presc(load_presc), .periodic(periodic),
    .start(start), .stop(stop), .irq_clear(irq_clear), .value(value),
    .running(running), .tc_pulse(tc_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v, input logic [3:0] p, input logic per);
    load_valid = 1'b1;
    load_value = v;
    load_presc = p;
    periodic   = per;
    step();
    load_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_value", value, 0);
    chk("rst_running", running, 0);
    chk("rst_tc", tc_pulse, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ready", load_ready, 1);
    step();
    reset = 1'b1;
    // one-shot 5, P=0
    load(8'd5, 4'd0, 1'b0);
    chk("os_loaded", value, 5);
    chk("os_idle", running, 0);
    go();
    chk("os_run", running, 1);
    chk("os_ready_low", load_ready, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("os_count", value, i);
      chk("os_no_tc", tc_pulse, 0);
    end
    step();
    chk("os_zero", value, 0);
    chk("os_tc", tc_pulse, 1);
    chk("os_stopped", running, 0);
    chk("os_irq", irq, 1);
    chk("os_ready", load_ready, 1);
    step();
    chk("os_tc_one_cycle", tc_pulse, 0);
    chk("os_no_underflow", value, 0);
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    chk("irq_cleared", irq, 0);
    // prescale: 2 with P=3, tc 8 clocks after start
    load(8'd2, 4'd3, 1'b0);
    go();
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("ps_value", value, i < 4 ? 2 : i < 8 ? 1 : 0);
      chk("ps_tc", tc_pulse, i == 8);
    end
    // periodic 3, P=0
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    load(8'd3, 4'd0, 1'b1);
    go();
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("per_value", value, (i % 3 == 1) ? 2 : (i % 3 == 2) ? 1 : 3);
      chk("per_tc", tc_pulse, i % 3 == 0);
      chk("per_running", running, 1);
    end
    load_valid = 1'b1;
    load_value = 8'd9;
    step();
    load_valid = 1'b0;
    chk("busy_load_ignored", value, 2);
    chk("busy_running", running, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_hold", value, 2);
    chk("stop_idle", running, 0);
    chk("stop_no_tc", tc_pulse, 0);
    go();
    chk("resume_value", value, 2);
    chk("resume_run", running, 1);
    irq_clear = 1'b1;
    step();
    chk("clr_irq", irq, 0);
    chk("resume_dec", value, 1);
    step();
    irq_clear = 1'b0;
    chk("race_irq_set_wins", irq, 1);
    chk("race_tc", tc_pulse, 1);
    chk("race_reload", value, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    // load+start together, then start with zero
    load_valid = 1'b1;
    load_value = 8'd6;
    start = 1'b1;
    step();
    load_valid = 1'b0;
    start = 1'b0;
    chk("ld_start_value", value, 6);
    chk("ld_start_idle", running, 0);
    load(8'd0, 4'd0, 1'b0);
    go();
    chk("zero_start", running, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_noop", value, 0);
    // async reset mid-run
    load(8'd7, 4'd2, 1'b0);
    go();
    step();
    step();
    chk("pre_rst_value", value, 7);
    chk("pre_rst_run", running, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_value", value, 0);
    chk("arst_running", running, 0);
    chk("arst_ready", load_ready, 1);
    chk("arst_tc", tc_pulse, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_run", running, 0);
      chk("post_rst_value", value, 0);
      chk("post_rst_tc", tc_pulse, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
